// File: rtl/demo_alu_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the demo ALU.
// Imported by the ALU top, its iterative unit and the bench.
package demo_alu_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_NOT    = 4'd2,
    OP_XOR    = 4'd3,
    OP_XNOR   = 4'd4,
    OP_ADD    = 4'd5,
    OP_SUB    = 4'd6,
    OP_SLL    = 4'd7,
    OP_SRL    = 4'd8,
    OP_SRA    = 4'd9,
    OP_ROL    = 4'd10,
    OP_POPCNT = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1
  } alu_state_e;

  // Shift/rotate ops consume B as a bit-position count.
  function automatic logic is_shift_op(input logic [OPW-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROL);
  endfunction

  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    return op <= OP_POPCNT;
  endfunction

endpackage

// File: rtl/demo_alu_iter.sv
// Iterative unit: one shift/rotate position or one popcount bit per step.
// Exposes the post-step result so the top can register it on the final step.
module demo_alu_iter
  import demo_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int CW = SHW + 1;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    pcnt_q;
  logic [CW-1:0]    pcnt_next;
  logic [CW-1:0]    cnt_q;
  logic [OPW-1:0]   op_q;

  always_comb begin
    acc_next  = acc_q;
    pcnt_next = pcnt_q;
    case (op_q)
      OP_SLL:    acc_next = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:    acc_next = {1'b0, acc_q[WIDTH-1:1]};
      OP_SRA:    acc_next = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
      OP_ROL:    acc_next = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
      OP_POPCNT: begin
        acc_next  = {1'b0, acc_q[WIDTH-1:1]};
        pcnt_next = pcnt_q + CW'(acc_q[0]);
      end
      default:   acc_next = acc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      pcnt_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
    end else if (load) begin
      acc_q  <= a;
      pcnt_q <= '0;
      op_q   <= op;
      // Popcount always walks every bit of A; shifts walk the requested amount.
      cnt_q  <= (op == OP_POPCNT) ? CW'(WIDTH) : {1'b0, amount};
    end else if (step) begin
      acc_q  <= acc_next;
      pcnt_q <= pcnt_next;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign last   = (cnt_q == CW'(1));
  assign result = (op_q == OP_POPCNT) ? WIDTH'(pcnt_next) : acc_next;

endmodule

// File: rtl/demo_alu.sv
// Parametrised demo ALU: single-cycle logic/arithmetic ops plus iterative
// shift/rotate/popcount, with busy/done/err status and zero/carry flags.
module demo_alu
  import demo_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             carry,
  output alu_state_e       dbg_state
);

  // Handshake: start is a request sampled every edge and accepted only in
  // IDLE; done is a one-cycle pulse marking Y/zero/carry/err as updated.
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             accept;
  logic             go_iter;
  logic [SHW-1:0]   amt;
  logic             iter_step;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;

  logic [WIDTH-1:0] sc_y;
  logic             sc_carry;
  logic             sc_err;
  logic [WIDTH:0]   wide;

  logic [WIDTH-1:0] y_q;
  logic             done_q;
  logic             err_q;
  logic             zero_q;
  logic             carry_q;

  assign amt       = B[SHW-1:0];
  assign accept    = start && (state_q == ST_IDLE);
  // A zero-position shift has nothing to iterate and completes like a logic op.
  assign go_iter   = (op == OP_POPCNT) || (is_shift_op(op) && (amt != '0));
  assign iter_step = (state_q == ST_ITER);

  demo_alu_iter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept && go_iter),
    .step  (iter_step),
    .op    (op),
    .a     (A),
    .amount(amt),
    .result(iter_result),
    .last  (iter_last)
  );

  always_comb begin
    sc_y     = '0;
    sc_carry = 1'b0;
    sc_err   = 1'b0;
    wide     = '0;
    case (op)
      OP_AND:  sc_y = A & B;
      OP_OR:   sc_y = A | B;
      OP_NOT:  sc_y = ~A;
      OP_XOR:  sc_y = A ^ B;
      OP_XNOR: sc_y = ~(A ^ B);
      OP_ADD: begin
        wide     = {1'b0, A} + {1'b0, B};
        sc_y     = wide[WIDTH-1:0];
        sc_carry = wide[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the extended difference is the unsigned borrow.
        wide     = {1'b0, A} - {1'b0, B};
        sc_y     = wide[WIDTH-1:0];
        sc_carry = wide[WIDTH];
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROL: sc_y = A;
      OP_POPCNT: sc_y = '0;
      default: sc_err = !is_legal_op(op);
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && go_iter) state_d = ST_ITER;
      ST_ITER: if (iter_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept && !go_iter) begin
        y_q     <= sc_y;
        carry_q <= sc_carry;
        err_q   <= sc_err;
        zero_q  <= (sc_y == '0);
        done_q  <= 1'b1;
      end else if (iter_step && iter_last) begin
        y_q     <= iter_result;
        carry_q <= 1'b0;
        err_q   <= 1'b0;
        zero_q  <= (iter_result == '0);
        done_q  <= 1'b1;
      end
    end
  end

  assign busy      = (state_q == ST_ITER);
  assign done      = done_q;
  assign err       = err_q;
  assign Y         = y_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_demo_alu.sv
// Bench for demo_alu at WIDTH=32 and WIDTH=8: directed corner cases plus
// random ops checked against an arithmetic reference model.
module tb_demo_alu;
  import demo_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start32, busy32, done32, err32, zero32, carry32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, y32;
  alu_state_e  st32;

  logic        start8, busy8, done8, err8, zero8, carry8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, y8;
  alu_state_e  st8;

  demo_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .err(err32), .Y(y32), .zero(zero32),
    .carry(carry32), .dbg_state(st32)
  );

  demo_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .err(err8), .Y(y8), .zero(zero8),
    .carry(carry8), .dbg_state(st8)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: result, flags and completion latency from the op definitions.
  task automatic model(input int w, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] y,
                       output logic c, output logic e, output int lat);
    logic [63:0] mask, s;
    int amt;
    mask = (64'd1 << w) - 64'd1;
    amt  = int'(b % 64'(w));
    y = 0; c = 0; e = 0; lat = 1;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = ~a & mask;
      4'd3: y = a ^ b;
      4'd4: y = ~(a ^ b) & mask;
      4'd5: begin s = a + b; y = s & mask; c = s[w]; end
      4'd6: begin y = (a - b) & mask; c = (a < b); end
      4'd7: y = (a << amt) & mask;
      4'd8: y = a >> amt;
      4'd9: begin
        y = a >> amt;
        if (a[w-1]) y = (y | (mask & ~(mask >> amt)));
      end
      4'd10: y = (amt == 0) ? a : (((a << amt) | (a >> (w - amt))) & mask);
      4'd11: y = 64'($countones(a & mask));
      default: e = 1;
    endcase
    if (op >= 4'd7 && op <= 4'd10) lat = amt + 1;
    if (op == 4'd11) lat = w + 1;
  endtask

  task automatic drive(input int w, input logic s, input logic [3:0] o,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin start32 = s; op32 = o; a32 = a[31:0]; b32 = b[31:0]; end
    else begin start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
  endtask

  task automatic set_start(input int w, input logic s);
    if (w == 32) start32 = s; else start8 = s;
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic er,
                        output logic zr, output logic cy, output logic [63:0] y);
    if (w == 32) begin bz = busy32; dn = done32; er = err32; zr = zero32; cy = carry32; y = 64'(y32); end
    else begin bz = busy8; dn = done8; er = err8; zr = zero8; cy = carry8; y = 64'(y8); end
  endtask

  // One op from request to done; optionally pokes an AND start while busy.
  task automatic run_op(input int w, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input bit poke, input string tag);
    logic [63:0] ey, y;
    logic ec, ee, bz, dn, er, zr, cy;
    int lat, cyc, busy_cnt, overlap;
    model(w, op, a, b, ey, ec, ee, lat);
    @(negedge clk);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    cyc = 1; busy_cnt = 0; overlap = 0;
    sample(w, bz, dn, er, zr, cy, y);
    while (!dn && cyc < 200) begin
      if (bz) busy_cnt++;
      if (poke && cyc == 2) begin
        @(negedge clk);
        drive(w, 1'b1, 4'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        @(posedge clk); #1;
        set_start(w, 1'b0);
      end else begin
        @(posedge clk); #1;
      end
      cyc++;
      sample(w, bz, dn, er, zr, cy, y);
      if (bz && dn) overlap++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(lat - 1));
    check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    check({tag, "_y"}, y, ey);
    check({tag, "_carry"}, 64'(cy), 64'(ec));
    check({tag, "_err"}, 64'(er), 64'(ee));
    check({tag, "_zero"}, 64'(zr), 64'(ey == 0));
    @(posedge clk); #1;
    sample(w, bz, dn, er, zr, cy, y);
    check({tag, "_done_single_pulse"}, 64'(dn), 64'd0);
    check({tag, "_y_held"}, y, ey);
  endtask

  initial begin
    logic [63:0] y, ey, ra, rb;
    logic bz, dn, er, zr, cy, ec, ee;
    logic [3:0] rop;
    int lat;

    rst = 1'b1;
    drive(32, 1'b0, 4'd0, 0, 0);
    drive(8, 1'b0, 4'd0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    sample(32, bz, dn, er, zr, cy, y);
    check("rst_y", y, 0);
    check("rst_flags", {59'd0, bz, dn, er, zr, cy}, 0);
    check("rst_state", 64'(st32), 64'(ST_IDLE));
    sample(8, bz, dn, er, zr, cy, y);
    check("rst8_y_flags", {y[58:0], bz, dn, er, zr, cy}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(32, 4'd0, 64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, "and");
    run_op(32, 4'd5, 64'hFFFF_FFFF, 64'd1, 1'b0, "add_wrap");
    run_op(32, 4'd6, 64'd1, 64'd2, 1'b0, "sub_borrow");
    run_op(32, 4'd9, 64'h8000_0000, 64'd4, 1'b1, "sra_poke");
    run_op(32, 4'd11, 64'h0000_00FF, 64'd0, 1'b0, "popcnt");
    run_op(32, 4'd10, 64'h8000_0001, 64'd0, 1'b0, "rol_zero_amt");
    run_op(32, 4'd13, 64'h1234_5678, 64'd3, 1'b0, "illegal");
    run_op(32, 4'd1, 64'h0000_1200, 64'h0000_0034, 1'b0, "or_clears_err");
    run_op(32, 4'd10, 64'hC000_0003, 64'd31, 1'b0, "rol_max");

    // Back-to-back single-cycle ops: one done per cycle, in order.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rop = 4'($urandom_range(0, 6));
      ra = 64'($urandom); rb = 64'($urandom);
      model(32, rop, ra, rb, ey, ec, ee, lat);
      exp_q.push_back(ey[31:0]);
      drive(32, 1'b1, rop, ra, rb);
      @(posedge clk); #1;
      sample(32, bz, dn, er, zr, cy, y);
      check("b2b_done", 64'(dn), 64'd1);
      check("b2b_y", y, 64'(exp_q.pop_front()));
    end
    @(negedge clk);
    set_start(32, 1'b0);

    // Reset in the middle of a 10-position rotate.
    run_op(32, 4'd0, 64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, "pre_rst_and");
    @(negedge clk);
    drive(32, 1'b1, 4'd10, 64'h8000_0001, 64'd10);
    @(posedge clk); #1;
    set_start(32, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sample(32, bz, dn, er, zr, cy, y);
    check("midrst_y", y, 0);
    check("midrst_flags", {59'd0, bz, dn, er, zr, cy}, 0);
    dn = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      dn = dn | done32;
      if (i == 1) rst = 1'b0;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    run_op(32, 4'd5, 64'd100, 64'd23, 1'b0, "post_rst_add");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(32, rop, 64'($urandom), 64'($urandom), 1'b0, $sformatf("rand32_op%0d", rop));
    end

    run_op(8, 4'd0, 64'hF0, 64'h3C, 1'b0, "and8");
    run_op(8, 4'd5, 64'hFF, 64'h01, 1'b0, "add8_wrap");
    run_op(8, 4'd5, 64'h7F, 64'h01, 1'b0, "add8_nocarry");
    run_op(8, 4'd11, 64'hA5, 64'd0, 1'b0, "popcnt8");
    for (int i = 0; i < 15; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op(8, rop, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)), 1'b0,
             $sformatf("rand8_op%0d", rop));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
